// File: rtl/score_seg_display.sv
// score_seg_display: binary score to BCD plus a
// multiplexed common-anode seven-segment driver.
module score_seg_display #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLINK_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    input  logic       game_complete,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       bcd_valid,
    output logic       conv_busy,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DONE  = 7'h21;

    typedef enum logic [1:0] {
        IDLE,
        ADJ,
        SHIFT,
        DONE
    } conv_state_t;

    conv_state_t state_q, state_nxt;

    logic [7:0]  bin_q, bin_nxt;
    logic [11:0] scratch_q, scratch_nxt;
    logic [3:0]  iter_q, iter_nxt;
    logic [7:0]  last_q, last_nxt;
    logic        pending_q, pending_nxt;
    logic [3:0]  hun_q, hun_nxt;
    logic [3:0]  ten_q, ten_nxt;
    logic [3:0]  one_q, one_nxt;
    logic        valid_q, valid_nxt;

    logic          gc_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_nxt;
    logic          blink_on_q, blink_on_nxt;
    logic [RW-1:0] ref_cnt_q, ref_cnt_nxt;
    logic [1:0]    idx_q, idx_nxt;
    logic [6:0]    seg_q, seg_nxt;
    logic [3:0]    an_q, an_nxt;

    function automatic logic [3:0] adj3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Converter state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            last_q    <= '0;
            pending_q <= 1'b1;
            hun_q     <= '0;
            ten_q     <= '0;
            one_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            bin_q     <= bin_nxt;
            scratch_q <= scratch_nxt;
            iter_q    <= iter_nxt;
            last_q    <= last_nxt;
            pending_q <= pending_nxt;
            hun_q     <= hun_nxt;
            ten_q     <= ten_nxt;
            one_q     <= one_nxt;
            valid_q   <= valid_nxt;
        end
    end

    // Double-dabble sequencing: one add-3 pass and one shift per bit.
    always_comb begin
        state_nxt   = state_q;
        bin_nxt     = bin_q;
        scratch_nxt = scratch_q;
        iter_nxt    = iter_q;
        last_nxt    = last_q;
        pending_nxt = pending_q;
        hun_nxt     = hun_q;
        ten_nxt     = ten_q;
        one_nxt     = one_q;
        valid_nxt   = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pending_q || (score != last_q)) begin
                    bin_nxt     = score;
                    last_nxt    = score;
                    scratch_nxt = '0;
                    iter_nxt    = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = ADJ;
                end
            end
            ADJ: begin
                scratch_nxt = {adj3(scratch_q[11:8]),
                               adj3(scratch_q[7:4]),
                               adj3(scratch_q[3:0])};
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                {scratch_nxt, bin_nxt} = {scratch_q, bin_q} << 1;
                iter_nxt  = iter_q + 4'd1;
                state_nxt = (iter_q == 4'd7) ? DONE : ADJ;
            end
            DONE: begin
                hun_nxt   = scratch_q[11:8];
                ten_nxt   = scratch_q[7:4];
                one_nxt   = scratch_q[3:0];
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Display timing: refresh scan, blink phase, registered seg/an.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc_q        <= 1'b0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 4'b1110;
        end else begin
            gc_q        <= game_complete;
            blink_cnt_q <= blink_cnt_nxt;
            blink_on_q  <= blink_on_nxt;
            ref_cnt_q   <= ref_cnt_nxt;
            idx_q       <= idx_nxt;
            seg_q       <= seg_nxt;
            an_q        <= an_nxt;
        end
    end

    // Next scan slot and glyph, so seg and an always switch together.
    always_comb begin
        ref_cnt_nxt   = ref_cnt_q + RW'(1);
        idx_nxt       = idx_q;
        blink_cnt_nxt = blink_cnt_q;
        blink_on_nxt  = blink_on_q;
        seg_nxt       = SEG_BLANK;
        an_nxt        = 4'b1110;

        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_nxt = '0;
            idx_nxt     = idx_q + 2'd1;
        end

        if (!game_complete) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = 1'b1;
        end else if (!gc_q) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = 1'b1;
        end else if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_nxt = '0;
            blink_on_nxt  = ~blink_on_q;
        end else begin
            blink_cnt_nxt = blink_cnt_q + BW'(1);
        end

        unique case (idx_nxt)
            2'd0: begin
                an_nxt  = 4'b1110;
                seg_nxt = seg_code(one_q);
            end
            2'd1: begin
                an_nxt = 4'b1101;
                if ((hun_q != 4'd0) || (ten_q != 4'd0))
                    seg_nxt = seg_code(ten_q);
            end
            2'd2: begin
                an_nxt = 4'b1011;
                if (hun_q != 4'd0)
                    seg_nxt = seg_code(hun_q);
            end
            2'd3: begin
                an_nxt = 4'b0111;
                if (game_complete)
                    seg_nxt = SEG_DONE;
            end
            default: an_nxt = 4'b1110;
        endcase

        if (!valid_q || !blink_on_nxt)
            seg_nxt = SEG_BLANK;
    end

    assign bcd_hundreds = hun_q;
    assign bcd_tens     = ten_q;
    assign bcd_ones     = one_q;
    assign bcd_valid    = valid_q;
    assign conv_busy    = (state_q != IDLE);
    assign seg          = seg_q;
    assign an           = an_q;

endmodule
